// File: rtl/spi_sclk_gen_if.sv
// Control and status bundle between the SPI master FSM and the SCLK generator.
interface spi_sclk_gen_if #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 6
);
    logic                 start;
    logic                 abort;
    logic [DIV_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] num_bits;
    logic                 cpol;
    logic                 cpha;
    logic                 sclk;
    logic                 sample_stb;
    logic                 shift_stb;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] bit_idx;

    // Control side: requests bursts and consumes strobes/status.
    modport master (
        output start, abort, div, num_bits, cpol, cpha,
        input  sclk, sample_stb, shift_stb, busy, done, bit_idx
    );

    // Generator side.
    modport slave (
        input  start, abort, div, num_bits, cpol, cpha,
        output sclk, sample_stb, shift_stb, busy, done, bit_idx
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides clk into SCLK for a burst of num_bits
// bits in any CPOL/CPHA mode and emits single-cycle sample/shift strobes.
module spi_sclk_gen #(
    parameter int unsigned DIV_WIDTH = 8,
    parameter int unsigned CNT_WIDTH = 6
) (
    input logic          clk,
    input logic          rst,
    spi_sclk_gen_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [DIV_WIDTH-1:0] r_hcnt,      w_hcnt_nxt;
    logic [DIV_WIDTH-1:0] r_div,       w_div_nxt;
    logic [CNT_WIDTH-1:0] r_num,       w_num_nxt;
    logic                 r_cpol,      w_cpol_nxt;
    logic                 r_cpha,      w_cpha_nxt;
    logic                 r_sclk,      w_sclk_nxt;
    logic                 r_sample,    w_sample_nxt;
    logic                 r_shift,     w_shift_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_done,      w_done_nxt;
    logic [CNT_WIDTH-1:0] r_bit_idx,   w_bit_idx_nxt;
    logic [CNT_WIDTH-1:0] w_bit_inc;

    assign w_bit_inc = r_bit_idx + CNT_WIDTH'(1);

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_hcnt    <= '0;
            r_div     <= '0;
            r_num     <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_sclk    <= 1'b0;
            r_sample  <= 1'b0;
            r_shift   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_div     <= w_div_nxt;
            r_num     <= w_num_nxt;
            r_cpol    <= w_cpol_nxt;
            r_cpha    <= w_cpha_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sample  <= w_sample_nxt;
            r_shift   <= w_shift_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    // Next-state and next-output logic; a half-period event fires when the counter hits the divisor.
    always_comb begin
        w_state_nxt   = r_state;
        w_hcnt_nxt    = r_hcnt;
        w_div_nxt     = r_div;
        w_num_nxt     = r_num;
        w_cpol_nxt    = r_cpol;
        w_cpha_nxt    = r_cpha;
        w_sclk_nxt    = r_sclk;
        w_sample_nxt  = 1'b0;
        w_shift_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bit_idx_nxt = r_bit_idx;

        case (r_state)
            ST_IDLE: begin
                w_sclk_nxt = bus.cpol;
                if (bus.start && !bus.abort) begin
                    if (bus.num_bits != '0) begin
                        w_div_nxt     = bus.div;
                        w_num_nxt     = bus.num_bits;
                        w_cpol_nxt    = bus.cpol;
                        w_cpha_nxt    = bus.cpha;
                        w_hcnt_nxt    = '0;
                        w_bit_idx_nxt = '0;
                        w_busy_nxt    = 1'b1;
                        w_state_nxt   = ST_RUN;
                    end else begin
                        // Empty burst completes immediately with no SCLK activity.
                        w_done_nxt = 1'b1;
                    end
                end
            end

            ST_RUN, ST_HOLD: begin
                if (bus.abort) begin
                    w_state_nxt   = ST_IDLE;
                    w_sclk_nxt    = r_cpol;
                    w_busy_nxt    = 1'b0;
                    w_bit_idx_nxt = '0;
                    w_hcnt_nxt    = '0;
                end else if (r_hcnt == r_div) begin
                    w_hcnt_nxt = '0;
                    if (r_state == ST_HOLD) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_sclk_nxt = ~r_sclk;
                        if (r_sclk == r_cpol) begin
                            // Leading edge.
                            if (r_cpha) w_shift_nxt  = 1'b1;
                            else        w_sample_nxt = 1'b1;
                        end else begin
                            // Trailing edge completes a bit; the last one has no following shift.
                            w_bit_idx_nxt = w_bit_inc;
                            if (r_cpha)                w_sample_nxt = 1'b1;
                            else if (w_bit_inc != r_num) w_shift_nxt = 1'b1;
                            if (w_bit_inc == r_num)    w_state_nxt  = ST_HOLD;
                        end
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + DIV_WIDTH'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.sclk       = r_sclk;
    assign bus.sample_stb = r_sample;
    assign bus.shift_stb  = r_shift;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen: per-cycle expected outputs are pushed
// to a scoreboard queue as stimulus is driven and popped at the next negedge.
module tb_spi_sclk_gen;

    logic clk = 1'b0;
    logic rst;

    spi_sclk_gen_if #(.DIV_WIDTH(8), .CNT_WIDTH(6)) bus();

    spi_sclk_gen #(.DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [10:0] q[$];
    logic [5:0]  last_idx;

    // Output vector layout: {sclk, sample, shift, busy, done, bit_idx[5:0]}.
    function automatic logic [10:0] outs();
        return {bus.sclk, bus.sample_stb, bus.shift_stb, bus.busy, bus.done, bus.bit_idx};
    endfunction

    // Expected outputs j cycles after the accepting edge E0 of a burst.
    function automatic logic [10:0] model(int j, int dv, int n, logic cp, logic ph);
        int p; int len; int m;
        logic sc, sa, sh, bz, dn;
        logic [5:0] bi;
        p = dv + 1;
        len = (2 * n + 1) * p;
        sa = 1'b0; sh = 1'b0; dn = 1'b0;
        if (j >= len) begin
            sc = cp; bz = 1'b0; dn = (j == len); bi = 6'(n);
        end else begin
            m  = j / p;
            bz = 1'b1;
            sc = cp ^ (m % 2 == 1);
            bi = 6'(m / 2);
            if (m >= 1 && (j % p) == 0) begin
                if (m % 2 == 1) begin
                    if (ph) sh = 1'b1; else sa = 1'b1;
                end else begin
                    if (ph) sa = 1'b1;
                    else if (m / 2 != n) sh = 1'b1;
                end
            end
        end
        return {sc, sa, sh, bz, dn, bi};
    endfunction

    task automatic test_reset();
        logic [10:0] a, e;
        rst = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.div = 8'd0; bus.num_bits = 6'd0;
        bus.cpol = 1'b1; bus.cpha = 1'b0;
        #12;
        @(negedge clk);
        q.push_back(11'b0);
        a = outs(); e = q.pop_front(); n_vec++;
        if (a !== e) begin n_miss++; $display("FAIL reset got=%b exp=%b", a, e); end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cpol = (i < 2);
            q.push_back({(i < 2), 10'b0});
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL idle_cpol i=%0d got=%b exp=%b", i, a, e); end
        end
        last_idx = 6'd0;
    endtask

    task automatic test_mode0_div0();
        logic [10:0] a, e;
        logic prev_sclk;
        int n_samp, n_shift, n_done, n_tog, n_busy;
        n_samp = 0; n_shift = 0; n_done = 0; n_tog = 0; n_busy = 0;
        prev_sclk = bus.sclk;
        for (int j = 0; j <= 18; j++) begin
            bus.start = (j == 0);
            if (j == 0) begin bus.div = 8'd0; bus.num_bits = 6'd8; bus.cpol = 1'b0; bus.cpha = 1'b0; end
            q.push_back(model(j, 0, 8, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL mode0 j=%0d got=%b exp=%b", j, a, e); end
            n_samp  += int'(a[9]);
            n_shift += int'(a[8]);
            n_busy  += int'(a[7]);
            n_done  += int'(a[6]);
            if (a[10] != prev_sclk) n_tog++;
            prev_sclk = a[10];
        end
        n_vec++; if (n_samp != 8)   begin n_miss++; $display("FAIL mode0_samples got=%0d exp=8", n_samp); end
        n_vec++; if (n_shift != 7)  begin n_miss++; $display("FAIL mode0_shifts got=%0d exp=7", n_shift); end
        n_vec++; if (n_busy != 17)  begin n_miss++; $display("FAIL mode0_busy got=%0d exp=17", n_busy); end
        n_vec++; if (n_done != 1)   begin n_miss++; $display("FAIL mode0_done got=%0d exp=1", n_done); end
        n_vec++; if (n_tog != 16)   begin n_miss++; $display("FAIL mode0_toggles got=%0d exp=16", n_tog); end
        last_idx = 6'd8;
    endtask

    task automatic test_mode3_div3();
        logic [10:0] a, e;
        int n_samp, n_shift, n_done, n_busy;
        n_samp = 0; n_shift = 0; n_done = 0; n_busy = 0;
        for (int j = 0; j <= 37; j++) begin
            bus.start = (j == 0);
            if (j == 0) begin bus.div = 8'd3; bus.num_bits = 6'd4; bus.cpol = 1'b1; bus.cpha = 1'b1; end
            q.push_back(model(j, 3, 4, 1'b1, 1'b1));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL mode3 j=%0d got=%b exp=%b", j, a, e); end
            if (a[9] && a[10] != 1'b1) begin n_miss++; $display("FAIL mode3_sample_edge j=%0d sclk=%b exp=1", j, a[10]); end
            if (a[8] && a[10] != 1'b0) begin n_miss++; $display("FAIL mode3_shift_edge j=%0d sclk=%b exp=0", j, a[10]); end
            n_samp  += int'(a[9]);
            n_shift += int'(a[8]);
            n_busy  += int'(a[7]);
            n_done  += int'(a[6]);
        end
        n_vec++; if (n_samp != 4)  begin n_miss++; $display("FAIL mode3_samples got=%0d exp=4", n_samp); end
        n_vec++; if (n_shift != 4) begin n_miss++; $display("FAIL mode3_shifts got=%0d exp=4", n_shift); end
        n_vec++; if (n_busy != 36) begin n_miss++; $display("FAIL mode3_busy got=%0d exp=36", n_busy); end
        n_vec++; if (n_done != 1)  begin n_miss++; $display("FAIL mode3_done got=%0d exp=1", n_done); end
        last_idx = 6'd4;
    endtask

    task automatic test_abort();
        logic [10:0] a, e;
        // start and abort together in idle: start dropped.
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.div = 8'd2; bus.num_bits = 6'd8;
        bus.start = 1'b1; bus.abort = 1'b1;
        q.push_back({1'b0, 4'b0, last_idx});
        @(posedge clk); @(negedge clk);
        a = outs(); e = q.pop_front(); n_vec++;
        if (a !== e) begin n_miss++; $display("FAIL start_abort_idle got=%b exp=%b", a, e); end
        bus.abort = 1'b0;
        for (int j = 0; j <= 28; j++) begin
            bus.start = (j == 0) || (j == 17);
            bus.abort = (j == 16);
            if (j == 0)  begin bus.div = 8'd2; bus.num_bits = 6'd8; end
            if (j == 17) begin bus.div = 8'd1; bus.num_bits = 6'd2; end
            if (j < 16)       q.push_back(model(j, 2, 8, 1'b0, 1'b0));
            else if (j == 16) q.push_back(11'b0);
            else              q.push_back(model(j - 17, 1, 2, 1'b0, 1'b0));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL abort j=%0d got=%b exp=%b", j, a, e); end
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        last_idx = 6'd2;
    endtask

    task automatic test_zero_len_and_ignore();
        logic [10:0] a, e;
        bus.cpol = 1'b0; bus.cpha = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            bus.start = (j == 0) || (j == 2) || (j == 6) || (j == 11);
            if (j == 0)             begin bus.div = 8'd5; bus.num_bits = 6'd0; end
            if (j == 2)             begin bus.div = 8'd1; bus.num_bits = 6'd3; end
            if (j == 6 || j == 11)  begin bus.div = 8'd0; bus.num_bits = 6'd7; end
            if (j == 0)      q.push_back({1'b0, 3'b0, 1'b1, last_idx});
            else if (j == 1) q.push_back({1'b0, 3'b0, 1'b0, last_idx});
            else             q.push_back(model(j - 2, 1, 3, 1'b0, 1'b1));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL zero_ignore j=%0d got=%b exp=%b", j, a, e); end
        end
        bus.start = 1'b0;
        last_idx = 6'd3;
    endtask

    task automatic test_back_to_back();
        logic [10:0] a, e;
        int n_done;
        n_done = 0;
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        for (int j = 0; j <= 27; j++) begin
            bus.start = (j == 0) || (j == 11);
            if (j == 0) begin bus.div = 8'd1; bus.num_bits = 6'd2; end
            // Reprogram mid-burst; only the next start may pick these up.
            if (j == 3) begin bus.div = 8'd4; bus.num_bits = 6'd1; bus.cpol = 1'b1; bus.cpha = 1'b1; end
            if (j <= 10) q.push_back(model(j, 1, 2, 1'b0, 1'b0));
            else         q.push_back(model(j - 11, 4, 1, 1'b1, 1'b1));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL b2b j=%0d got=%b exp=%b", j, a, e); end
            n_done += int'(a[6]);
        end
        bus.start = 1'b0;
        n_vec++; if (n_done != 2) begin n_miss++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        last_idx = 6'd1;
    endtask

    task automatic test_reset_mid();
        logic [10:0] a, e;
        bus.cpol = 1'b1; bus.cpha = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.start = (j == 0);
            if (j == 0) begin bus.div = 8'd0; bus.num_bits = 6'd5; end
            q.push_back(model(j, 0, 5, 1'b1, 1'b0));
            @(posedge clk); @(negedge clk);
            a = outs(); e = q.pop_front(); n_vec++;
            if (a !== e) begin n_miss++; $display("FAIL pre_reset j=%0d got=%b exp=%b", j, a, e); end
        end
        bus.start = 1'b0;
        rst = 1'b0;
        q.push_back(11'b0);
        #1;
        a = outs(); e = q.pop_front(); n_vec++;
        if (a !== e) begin n_miss++; $display("FAIL reset_mid got=%b exp=%b", a, e); end
        @(negedge clk);
        rst = 1'b1;
        q.push_back({1'b1, 10'b0});
        @(posedge clk); @(negedge clk);
        a = outs(); e = q.pop_front(); n_vec++;
        if (a !== e) begin n_miss++; $display("FAIL post_reset got=%b exp=%b", a, e); end
    endtask

    initial begin
        test_reset();
        test_mode0_div0();
        test_mode3_div3();
        test_abort();
        test_zero_len_and_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
